// File: rtl/mdr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdr_pkg
// Purpose  : Shared encodings for the MDR memory controller: access size
//            codes and controller state enumeration.
// Revision : 1.0 - initial release
// ============================================================================
package mdr_pkg;

  // Access size as presented on the size input; 2'b11 behaves as a word.
  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_WORD_X = 2'b11
  } mdr_size_e;

  // Controller states: idle, waiting for read ack, waiting for write ack.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD_WAIT = 2'b01,
    ST_WR_WAIT = 2'b10
  } mdr_state_e;

endpackage
`default_nettype wire

// File: rtl/mdr_lane_extract.sv
`default_nettype none
// ============================================================================
// Module   : mdr_lane_extract
// Purpose  : Combinational lane logic. Selects the addressed byte/half/word
//            from a memory word with zero or sign extension, and produces the
//            matching byte-enable mask and an alignment fault flag.
// Revision : 1.0 - initial release
// ============================================================================
module mdr_lane_extract
  import mdr_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int LANES      = DATA_WIDTH / 8,
  localparam int AW         = $clog2(LANES)
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [1:0]            i_size,
  input  logic                  i_sign,
  input  logic [AW-1:0]         i_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [LANES-1:0]      o_be,
  output logic                  o_misaligned
);

  logic [AW-1:0] w_half_addr;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  // A half-word always starts on an even lane, so the low address bit is dropped.
  assign w_half_addr = i_addr & ~AW'(1);
  assign w_byte      = 8'(i_data >> {i_addr, 3'b000});
  assign w_half      = 16'(i_data >> {w_half_addr, 3'b000});

  // Per-size data extension, lane mask and alignment check.
  always_comb begin
    o_data       = i_data;
    o_be         = '1;
    o_misaligned = (i_addr != '0);
    case (i_size)
      SZ_BYTE: begin
        o_data       = i_sign ? DATA_WIDTH'($signed(w_byte)) : DATA_WIDTH'(w_byte);
        o_be         = LANES'(1) << i_addr;
        o_misaligned = 1'b0;
      end
      SZ_HALF: begin
        o_data       = i_sign ? DATA_WIDTH'($signed(w_half)) : DATA_WIDTH'(w_half);
        o_be         = LANES'(3) << w_half_addr;
        o_misaligned = i_addr[0];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdr_mem_ctrl
// Purpose  : Memory data register with a byte/half/word memory access
//            sequencer. Issues reads/writes, waits for mem_ack with a bounded
//            timeout, aligns and extends read data into the MDR.
// Revision : 1.0 - initial release
// ============================================================================
module mdr_mem_ctrl
  import mdr_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int TIMEOUT    = 15,
  localparam int LANES      = DATA_WIDTH / 8,
  localparam int AW         = $clog2(LANES)
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  MDRin,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic                  start_rd,
  input  logic                  start_wr,
  input  logic [1:0]            size,
  input  logic                  sign,
  input  logic [AW-1:0]         addr_lo,
  input  logic [DATA_WIDTH-1:0] Mdatain,
  input  logic                  mem_ack,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [LANES-1:0]      mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mdr_q,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mdr_state_e            r_state;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            r_size;
  logic                  r_sign;
  logic [AW-1:0]         r_addr;
  logic [DATA_WIDTH-1:0] r_mdr;
  logic                  r_mem_rd;
  logic                  r_mem_wr;
  logic [LANES-1:0]      r_mem_be;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_in_wait;
  logic [1:0]            w_x_size;
  logic                  w_x_sign;
  logic [AW-1:0]         w_x_addr;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [LANES-1:0]      w_be;
  logic                  w_misaligned;
  logic [DATA_WIDTH-1:0] w_wdata;

  // One lane unit serves both phases: live request fields in IDLE (for the
  // byte enables and alignment check), latched fields while waiting (for the
  // read data extraction at ack time).
  assign w_in_wait = (r_state != ST_IDLE);
  assign w_x_size  = w_in_wait ? r_size : size;
  assign w_x_sign  = w_in_wait ? r_sign : sign;
  assign w_x_addr  = w_in_wait ? r_addr : addr_lo;

  mdr_lane_extract #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane (
    .i_data       (Mdatain),
    .i_size       (w_x_size),
    .i_sign       (w_x_sign),
    .i_addr       (w_x_addr),
    .o_data       (w_rd_data),
    .o_be         (w_be),
    .o_misaligned (w_misaligned)
  );

  // Write data: low byte or half of the MDR replicated over every lane.
  always_comb begin
    w_wdata = r_mdr;
    for (int i = 0; i < LANES; i++) begin
      if (size == SZ_BYTE) begin
        w_wdata[8*i +: 8] = r_mdr[7:0];
      end else if (size == SZ_HALF) begin
        w_wdata[8*i +: 8] = (i % 2 == 0) ? r_mdr[7:0] : r_mdr[15:8];
      end
    end
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_size      <= '0;
      r_sign      <= 1'b0;
      r_addr      <= '0;
      r_mdr       <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_rd || start_wr) begin
            if (w_misaligned) begin
              r_err <= 1'b1;
            end else begin
              r_size   <= size;
              r_sign   <= sign;
              r_addr   <= addr_lo;
              r_cnt    <= '0;
              r_mem_be <= w_be;
              r_busy   <= 1'b1;
              if (start_rd) begin
                r_state  <= ST_RD_WAIT;
                r_mem_rd <= 1'b1;
              end else begin
                r_state     <= ST_WR_WAIT;
                r_mem_wr    <= 1'b1;
                r_mem_wdata <= w_wdata;
              end
            end
          end else if (MDRin) begin
            r_mdr <= BusMuxOut;
          end
        end
        ST_RD_WAIT, ST_WR_WAIT: begin
          // An ack on the last allowed wait cycle still counts as success.
          if (mem_ack) begin
            if (r_state == ST_RD_WAIT) begin
              r_mdr <= w_rd_data;
            end
            r_done   <= 1'b1;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (r_cnt == CW'(TIMEOUT)) begin
            r_err    <= 1'b1;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_mem_rd <= 1'b0;
          r_mem_wr <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;
  assign mdr_q     = r_mdr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mdr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdr_mem_ctrl
// Purpose  : Scoreboard bench for mdr_mem_ctrl. The stimulus side predicts
//            each access outcome from a byte-lane reference model and queues
//            it; a monitor pops and compares on every done/err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdr_mem_ctrl;

  localparam int DW = 32;
  localparam int TO = 15;

  logic          clock = 1'b0;
  logic          clear_n = 1'b0;
  logic          MDRin = 1'b0;
  logic [DW-1:0] BusMuxOut = '0;
  logic          start_rd = 1'b0;
  logic          start_wr = 1'b0;
  logic [1:0]    size = '0;
  logic          sign = 1'b0;
  logic [1:0]    addr_lo = '0;
  logic [DW-1:0] Mdatain = '0;
  logic          mem_ack = 1'b0;
  logic          mem_rd, mem_wr, busy, done, err;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata, mdr_q;

  mdr_mem_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .clear_n(clear_n), .MDRin(MDRin), .BusMuxOut(BusMuxOut),
    .start_rd(start_rd), .start_wr(start_wr), .size(size), .sign(sign),
    .addr_lo(addr_lo), .Mdatain(Mdatain), .mem_ack(mem_ack),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mdr_q(mdr_q), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_err;
    bit          is_rd;
    int          cycles;   // cycles the strobe is expected high
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mdr;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_mdr = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // ---------------- reference model (byte-lane arithmetic) ----------------
  function automatic int ref_bytes(int sz);
    return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] ref_be(int n, int a);
    return 4'(((1 << n) - 1) << a);
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] md, int n, int a, bit sg);
    longint mask = (64'd1 << (8 * n)) - 1;
    longint v    = (longint'(md) >> (8 * a)) & mask;
    if (sg && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_wdata(logic [31:0] m, int n);
    longint mask = (64'd1 << (8 * n)) - 1;
    longint w    = 0;
    for (int i = 0; i < 4 / n; i++) w = w | ((longint'(m) & mask) << (8 * n * i));
    return w[31:0];
  endfunction

  // ---------------- monitor ----------------
  int          mon_rd_n = 0, mon_wr_n = 0;
  logic [3:0]  mon_be = '0;
  logic [31:0] mon_wd = '0;
  exp_t        mon_e;

  // Accumulates strobe activity and checks each completion against the queue.
  always @(negedge clock) begin
    if (!clear_n) begin
      mon_rd_n = 0;
      mon_wr_n = 0;
    end else begin
      if (mem_rd) begin mon_rd_n++; mon_be = mem_be; end
      if (mem_wr) begin mon_wr_n++; mon_be = mem_be; mon_wd = mem_wdata; end
      if (done || err) begin
        chk("done_err_exclusive", {31'b0, done & err}, 32'd0);
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: done=%b err=%b with no access outstanding", done, err);
        end else begin
          mon_e = q.pop_front();
          chk("done", {31'b0, done}, {31'b0, !mon_e.is_err});
          chk("err", {31'b0, err}, {31'b0, mon_e.is_err});
          chk("rd_cycles", mon_rd_n, mon_e.is_rd ? mon_e.cycles : 0);
          chk("wr_cycles", mon_wr_n, mon_e.is_rd ? 0 : mon_e.cycles);
          chk("strobe_dropped", {30'b0, mem_rd, mem_wr}, 32'd0);
          chk("busy_dropped", {31'b0, busy}, 32'd0);
          chk("mdr_q", mdr_q, mon_e.mdr);
          if (mon_e.cycles > 0) chk("mem_be", {28'b0, mon_be}, {28'b0, mon_e.be});
          if (mon_e.cycles > 0 && !mon_e.is_rd) chk("mem_wdata", mon_wd, mon_e.wdata);
        end
        mon_rd_n = 0;
        mon_wr_n = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    start_rd = 0; start_wr = 0; MDRin = 0; mem_ack = 0;
    Mdatain = $urandom; BusMuxOut = $urandom;
  endtask

  // Random activity on every request input while busy; all of it must be ignored.
  task automatic junk();
    start_rd = 1'($urandom); start_wr = 1'($urandom); MDRin = 1'($urandom);
    BusMuxOut = $urandom; size = 2'($urandom); sign = 1'($urandom);
    addr_lo = 2'($urandom); mem_ack = 0; Mdatain = $urandom;
  endtask

  task automatic load_mdr(logic [31:0] v);
    idle_inputs();
    MDRin = 1; BusMuxOut = v;
    tick();
    MDRin = 0;
    model_mdr = v;
    chk("mdr_load", mdr_q, v);
  endtask

  // d in 1..TO+1: ack arrives on the d-th wait cycle; d > TO+1: never acked.
  task automatic access(bit rd, int sz, bit sg, int a, logic [31:0] md, int d);
    exp_t e;
    int   n = ref_bytes(sz);
    bit   mis = (a % n) != 0;
    e.is_rd = rd;
    e.be    = ref_be(n, a);
    e.wdata = ref_wdata(model_mdr, n);
    if (mis) begin
      e.is_err = 1; e.cycles = 0;
    end else if (d <= TO + 1) begin
      e.is_err = 0; e.cycles = d;
      if (rd) model_mdr = ref_rd(md, n, a, sg);
    end else begin
      e.is_err = 1; e.cycles = TO + 1;
    end
    e.mdr = model_mdr;
    q.push_back(e);
    idle_inputs();
    start_rd = rd; start_wr = !rd; size = 2'(sz); sign = sg; addr_lo = 2'(a);
    MDRin = 1'($urandom);   // loses to the start request
    tick();
    idle_inputs();
    if (mis) begin
      tick();
      return;
    end
    for (int i = 1; i <= e.cycles; i++) begin
      junk();
      if (i == d) begin mem_ack = 1; Mdatain = md; end
      tick();
    end
    idle_inputs();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    chk("queue_drained", q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle_inputs();
    clear_n = 0;
    repeat (3) tick();
    chk("rst_mdr_q", mdr_q, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ctrl", {23'b0, mem_be, mem_rd, mem_wr, busy, done, err}, 0);
    clear_n = 1;
    tick();

    load_mdr(32'hDEADBEEF);
    access(1, 0, 1, 2, 32'h12F45678, 3);            // byte read, sign-extended
    drain();
    chk("byte_read_sext", mdr_q, 32'hFFFFFFF4);
    load_mdr(32'h0000ABCD);
    access(0, 1, 0, 2, 32'h0, 4);                   // half write, replicated
    access(1, 2, 0, 0, $urandom, TO + 2);           // word read, timeout
    access(1, 2, 0, 0, 32'hCAFEF00D, TO + 1);       // ack on last wait cycle
    access(1, 2, 0, 1, $urandom, 1);                // misaligned word
    access(0, 1, 0, 3, $urandom, 1);                // misaligned half
    access(1, 3, 1, 0, 32'h80000001, 1);            // size 3 acts as word
    access(0, 0, 0, 3, 32'h0, 1);                   // byte write, top lane
    drain();

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 1) == 1) load_mdr($urandom);
      access(1'($urandom), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
             $urandom, $urandom_range(1, TO + 2));
      if ($urandom_range(0, 3) == 0) begin          // stray ack while idle
        idle_inputs();
        mem_ack = 1;
        tick();
        idle_inputs();
      end
    end
    drain();

    // Reset in the middle of a read; the late ack must be dropped.
    load_mdr(32'h5A5A5A5A);
    idle_inputs();
    start_rd = 1; size = 2'b10; addr_lo = 0;
    tick();
    idle_inputs();
    repeat (3) tick();
    clear_n = 0;
    tick();
    clear_n = 1;
    model_mdr = 0;
    chk("midrst_mdr_q", mdr_q, 0);
    chk("midrst_ctrl", {23'b0, mem_be, mem_rd, mem_wr, busy, done, err}, 0);
    mem_ack = 1; Mdatain = 32'h13572468;
    tick();
    idle_inputs();
    repeat (4) tick();
    chk("late_ack_mdr_q", mdr_q, 0);
    chk("late_ack_ctrl", {29'b0, mem_rd, busy, done}, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
